// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multi-cycle MIPS datapath with memory req/ready watchdog.
// Optional performance counters are built when MULTICYCLE_PERF_CNT_EN is defined.
module multicycle_ctrl #(
    parameter int WAIT_MAX = 15,
    parameter int CNT_W    = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [5:0]  instr_op_i,
    input  logic        zero_i,
    input  logic        mem_ready_i,
    output logic        pc_write_o,
    output logic        ir_write_o,
    output logic        reg_write_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic        iord_o,
    output logic        alu_src_a_o,
    output logic [1:0]  alu_src_b_o,
    output logic [2:0]  alu_op_o,
    output logic        reg_dst_o,
    output logic        mem_to_reg_o,
    output logic        pc_src_o,
    output logic        illegal_o,
    output logic        timeout_o,
    output logic [3:0]  state_o,
    output logic [31:0] cycle_cnt_o,
    output logic [31:0] retire_cnt_o
);

    typedef enum logic [3:0] {
        IDLE   = 4'd0,  FETCH  = 4'd1,  DECODE = 4'd2,  EXEC_R = 4'd3,
        EXEC_I = 4'd4,  BRANCH = 4'd5,  MADDR  = 4'd6,  MRD    = 4'd7,
        MWR    = 4'd8,  WB_R   = 4'd9,  WB_I   = 4'd10, WB_MEM = 4'd11,
        HALT   = 4'd15
    } state_t;

    localparam logic [5:0] OP_R     = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    // The wait that would be the WAIT_MAX-th consecutive unanswered request cycle
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(WAIT_MAX - 1);

    state_t           state_q, state_d;
    logic [5:0]       op_q;
    logic [CNT_W-1:0] wait_q;
    logic             timeout_q;
    logic             mem_state;

    assign mem_state = (state_q == FETCH) || (state_q == MRD) || (state_q == MWR);
    assign state_o   = state_q;
    assign timeout_o = timeout_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q   <= IDLE;
            op_q      <= '0;
            wait_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == DECODE)
                op_q <= instr_op_i;
            if (mem_state && !mem_ready_i)
                wait_q <= wait_q + 1'b1;
            else
                wait_q <= '0;
            if (state_d == HALT)
                timeout_q <= 1'b1;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_write_o   = 1'b0;
        ir_write_o   = 1'b0;
        reg_write_o  = 1'b0;
        mem_req_o    = 1'b0;
        mem_we_o     = 1'b0;
        iord_o       = 1'b0;
        alu_src_a_o  = 1'b0;
        alu_src_b_o  = 2'd0;
        alu_op_o     = 3'd0;
        reg_dst_o    = 1'b0;
        mem_to_reg_o = 1'b0;
        pc_src_o     = 1'b0;
        illegal_o    = 1'b0;
        case (state_q)
            IDLE: state_d = FETCH;
            FETCH: begin
                mem_req_o   = 1'b1;
                alu_src_b_o = 2'd1;
                alu_op_o    = 3'd1;
                if (mem_ready_i) begin
                    ir_write_o = 1'b1;
                    pc_write_o = 1'b1;
                    state_d    = DECODE;
                end else if (wait_q == WAIT_LAST) begin
                    state_d = HALT;
                end
            end
            DECODE: begin
                alu_src_b_o = 2'd3;
                alu_op_o    = 3'd1;
                case (instr_op_i)
                    OP_R:                                   state_d = EXEC_R;
                    OP_ADDI, OP_SLTIU, OP_LUI, OP_ORI:      state_d = EXEC_I;
                    OP_BEQ, OP_BNE:                         state_d = BRANCH;
                    OP_LW, OP_SW:                           state_d = MADDR;
                    default: begin
                        illegal_o = 1'b1;
                        state_d   = FETCH;
                    end
                endcase
            end
            EXEC_R: begin
                alu_src_a_o = 1'b1;
                state_d     = WB_R;
            end
            EXEC_I: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = 2'd2;
                case (op_q)
                    OP_SLTIU: alu_op_o = 3'd2;
                    OP_LUI:   alu_op_o = 3'd4;
                    OP_ORI:   alu_op_o = 3'd5;
                    default:  alu_op_o = 3'd1;
                endcase
                state_d = WB_I;
            end
            BRANCH: begin
                alu_src_a_o = 1'b1;
                alu_op_o    = (op_q == OP_BNE) ? 3'd6 : 3'd3;
                pc_src_o    = 1'b1;
                pc_write_o  = ((op_q == OP_BEQ) && zero_i) || ((op_q == OP_BNE) && !zero_i);
                state_d     = FETCH;
            end
            MADDR: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = 2'd2;
                alu_op_o    = 3'd1;
                state_d     = (op_q == OP_SW) ? MWR : MRD;
            end
            MRD, MWR: begin
                mem_req_o = 1'b1;
                iord_o    = 1'b1;
                mem_we_o  = (state_q == MWR);
                if (mem_ready_i)
                    state_d = (state_q == MWR) ? FETCH : WB_MEM;
                else if (wait_q == WAIT_LAST)
                    state_d = HALT;
            end
            WB_R: begin
                reg_write_o = 1'b1;
                reg_dst_o   = 1'b1;
                state_d     = FETCH;
            end
            WB_I: begin
                reg_write_o = 1'b1;
                state_d     = FETCH;
            end
            WB_MEM: begin
                reg_write_o  = 1'b1;
                mem_to_reg_o = 1'b1;
                state_d      = FETCH;
            end
            HALT:    state_d = HALT;
            default: state_d = IDLE;
        endcase
    end

`ifdef MULTICYCLE_PERF_CNT_EN
    logic [31:0] cycle_q, retire_q;
    logic        retire;

    // Only completed instructions retire; an illegal opcode leaves DECODE without counting
    assign retire = (state_d == FETCH) &&
                    ((state_q == WB_R) || (state_q == WB_I) || (state_q == WB_MEM) ||
                     (state_q == BRANCH) || (state_q == MWR));

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cycle_q  <= '0;
            retire_q <= '0;
        end else begin
            if ((state_q != IDLE) && (state_q != HALT))
                cycle_q <= cycle_q + 32'd1;
            if (retire)
                retire_q <= retire_q + 32'd1;
        end
    end

    assign cycle_cnt_o  = cycle_q;
    assign retire_cnt_o = retire_q;
`else
    assign cycle_cnt_o  = '0;
    assign retire_cnt_o = '0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: cycle-by-cycle vector table plus watchdog,
// reset and performance-counter sequences.
module tb_multicycle_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [5:0]  instr_op_i;
    logic        zero_i;
    logic        mem_ready_i;
    logic        pc_write_o, ir_write_o, reg_write_o, mem_req_o, mem_we_o, iord_o;
    logic        alu_src_a_o;
    logic [1:0]  alu_src_b_o;
    logic [2:0]  alu_op_o;
    logic        reg_dst_o, mem_to_reg_o, pc_src_o, illegal_o, timeout_o;
    logic [3:0]  state_o;
    logic [31:0] cycle_cnt_o, retire_cnt_o;
    logic [15:0] dut_ctl;

    multicycle_ctrl #(.WAIT_MAX(15), .CNT_W(8)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .instr_op_i(instr_op_i), .zero_i(zero_i),
        .mem_ready_i(mem_ready_i), .pc_write_o(pc_write_o), .ir_write_o(ir_write_o),
        .reg_write_o(reg_write_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
        .iord_o(iord_o), .alu_src_a_o(alu_src_a_o), .alu_src_b_o(alu_src_b_o),
        .alu_op_o(alu_op_o), .reg_dst_o(reg_dst_o), .mem_to_reg_o(mem_to_reg_o),
        .pc_src_o(pc_src_o), .illegal_o(illegal_o), .timeout_o(timeout_o),
        .state_o(state_o), .cycle_cnt_o(cycle_cnt_o), .retire_cnt_o(retire_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    assign dut_ctl = {pc_write_o, ir_write_o, reg_write_o, mem_req_o, mem_we_o, iord_o,
                      alu_src_a_o, alu_src_b_o, alu_op_o, reg_dst_o, mem_to_reg_o,
                      pc_src_o, illegal_o};

    typedef struct {
        logic [5:0]  op;
        logic        zero;
        logic        rdy;
        logic [3:0]  st;
        logic [15:0] ctl;
        logic        to;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    localparam logic [5:0] OP_R = 6'b000000, OP_ADDI = 6'b001000, OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_LUI = 6'b001111, OP_ORI = 6'b001101, OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_BNE = 6'b000101, OP_LW = 6'b100011, OP_SW = 6'b101011;
    localparam logic [5:0] OP_BAD = 6'b111111;

    function automatic logic [15:0] mk(input logic pcw, irw, rw, req, we, iord, asa,
                                       input logic [1:0] asb, input logic [2:0] aop,
                                       input logic rd, m2r, psrc, ill);
        return {pcw, irw, rw, req, we, iord, asa, asb, aop, rd, m2r, psrc, ill};
    endfunction

    logic [15:0] C_FRDY, C_FWAIT, C_DEC, C_DECILL, C_EXR, C_WBR, C_WBI;
    logic [15:0] C_MADDR, C_MRD, C_MWR, C_WBM;

    function automatic vec_t row(input logic [5:0] op, input logic zero, rdy,
                                 input logic [3:0] st, input logic [15:0] ctl, input logic to);
        vec_t v;
        v.op = op; v.zero = zero; v.rdy = rdy; v.st = st; v.ctl = ctl; v.to = to;
        return v;
    endfunction

    task automatic add(input logic [5:0] op, input logic zero, rdy,
                       input logic [3:0] st, input logic [15:0] ctl);
        tbl.push_back(row(op, zero, rdy, st, ctl, 1'b0));
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input string tag);
        vec_t e;
        instr_op_i  = v.op;
        zero_i      = v.zero;
        mem_ready_i = v.rdy;
        sb.push_back(v);
        @(negedge clk_i);
        e = sb.pop_front();
        check({tag, " state"},   {28'd0, state_o}, {28'd0, e.st});
        check({tag, " ctl"},     {16'd0, dut_ctl}, {16'd0, e.ctl});
        check({tag, " timeout"}, {31'd0, timeout_o}, {31'd0, e.to});
        @(posedge clk_i);
        #1;
    endtask

    task automatic add_instr_i(input logic [5:0] op, input logic [2:0] aop);
        add(op, 0, 1, 4'd1, C_FRDY);
        add(op, 0, 1, 4'd2, C_DEC);
        add(op, 0, 1, 4'd4, mk(0,0,0,0,0,0,1,2'd2,aop,0,0,0,0));
        add(op, 0, 1, 4'd10, C_WBI);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got still running expected finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        C_FRDY   = mk(1,1,0,1,0,0,0,2'd1,3'd1,0,0,0,0);
        C_FWAIT  = mk(0,0,0,1,0,0,0,2'd1,3'd1,0,0,0,0);
        C_DEC    = mk(0,0,0,0,0,0,0,2'd3,3'd1,0,0,0,0);
        C_DECILL = mk(0,0,0,0,0,0,0,2'd3,3'd1,0,0,0,1);
        C_EXR    = mk(0,0,0,0,0,0,1,2'd0,3'd0,0,0,0,0);
        C_WBR    = mk(0,0,1,0,0,0,0,2'd0,3'd0,1,0,0,0);
        C_WBI    = mk(0,0,1,0,0,0,0,2'd0,3'd0,0,0,0,0);
        C_MADDR  = mk(0,0,0,0,0,0,1,2'd2,3'd1,0,0,0,0);
        C_MRD    = mk(0,0,0,1,0,1,0,2'd0,3'd0,0,0,0,0);
        C_MWR    = mk(0,0,0,1,1,1,0,2'd0,3'd0,0,0,0,0);
        C_WBM    = mk(0,0,1,0,0,0,0,2'd0,3'd0,0,1,0,0);

        add(OP_R, 0, 1, 4'd0, 16'd0);
        add(OP_R, 0, 1, 4'd1, C_FRDY);
        add(OP_R, 0, 1, 4'd2, C_DEC);
        add(OP_R, 0, 1, 4'd3, C_EXR);
        add(OP_R, 0, 1, 4'd9, C_WBR);
        // Branches: BEQ taken, BNE with zero=1 not taken, BNE with zero=0 taken
        add(OP_BEQ, 1, 1, 4'd1, C_FRDY);
        add(OP_BEQ, 1, 1, 4'd2, C_DEC);
        add(OP_BEQ, 1, 1, 4'd5, mk(1,0,0,0,0,0,1,2'd0,3'd3,0,0,1,0));
        add(OP_BNE, 1, 1, 4'd1, C_FRDY);
        add(OP_BNE, 1, 1, 4'd2, C_DEC);
        add(OP_BNE, 1, 1, 4'd5, mk(0,0,0,0,0,0,1,2'd0,3'd6,0,0,1,0));
        add(OP_BNE, 0, 1, 4'd1, C_FRDY);
        add(OP_BNE, 0, 1, 4'd2, C_DEC);
        add(OP_BNE, 0, 1, 4'd5, mk(1,0,0,0,0,0,1,2'd0,3'd6,0,0,1,0));
        add_instr_i(OP_ADDI, 3'd1);
        add_instr_i(OP_SLTIU, 3'd2);
        add_instr_i(OP_LUI, 3'd4);
        add_instr_i(OP_ORI, 3'd5);
        // LW with three wait states in MRD
        add(OP_LW, 0, 1, 4'd1, C_FRDY);
        add(OP_LW, 0, 1, 4'd2, C_DEC);
        add(OP_LW, 0, 1, 4'd6, C_MADDR);
        add(OP_LW, 0, 0, 4'd7, C_MRD);
        add(OP_LW, 0, 0, 4'd7, C_MRD);
        add(OP_LW, 0, 0, 4'd7, C_MRD);
        add(OP_LW, 0, 1, 4'd7, C_MRD);
        add(OP_LW, 0, 1, 4'd11, C_WBM);
        // SW after one fetch wait state
        add(OP_SW, 0, 0, 4'd1, C_FWAIT);
        add(OP_SW, 0, 1, 4'd1, C_FRDY);
        add(OP_SW, 0, 1, 4'd2, C_DEC);
        add(OP_SW, 0, 1, 4'd6, C_MADDR);
        add(OP_SW, 0, 1, 4'd8, C_MWR);
        add(OP_BAD, 0, 1, 4'd1, C_FRDY);
        add(OP_BAD, 0, 1, 4'd2, C_DECILL);
        add(OP_R, 0, 1, 4'd1, C_FRDY);
        add(OP_R, 0, 1, 4'd2, C_DEC);

        rst_i = 1'b0; instr_op_i = '0; zero_i = 1'b0; mem_ready_i = 1'b0;
        #12;
        check("reset state", {28'd0, state_o}, 32'd0);
        check("reset ctl", {16'd0, dut_ctl}, 32'd0);
        check("reset timeout", {31'd0, timeout_o}, 32'd0);
        @(posedge clk_i); #1;
        rst_i = 1'b1;

        for (int i = 0; i < tbl.size(); i++)
            apply(tbl[i], $sformatf("vec%0d", i));
        apply(row(OP_R, 0, 1, 4'd3, C_EXR, 0), "tail exec_r");
        apply(row(OP_R, 0, 1, 4'd9, C_WBR, 0), "tail wb_r");

        // LW accepted on the last permissible wait cycle: no timeout
        apply(row(OP_LW, 0, 1, 4'd1, C_FRDY, 0), "wd_lw fetch");
        apply(row(OP_LW, 0, 1, 4'd2, C_DEC, 0), "wd_lw decode");
        apply(row(OP_LW, 0, 1, 4'd6, C_MADDR, 0), "wd_lw maddr");
        for (int i = 0; i < 14; i++)
            apply(row(OP_LW, 0, 0, 4'd7, C_MRD, 0), $sformatf("wd_lw wait%0d", i));
        apply(row(OP_LW, 0, 1, 4'd7, C_MRD, 0), "wd_lw accept");
        apply(row(OP_LW, 0, 1, 4'd11, C_WBM, 0), "wd_lw wb_mem");

        // SW never acknowledged: 15 waiting cycles then HALT
        apply(row(OP_SW, 0, 1, 4'd1, C_FRDY, 0), "wd_sw fetch");
        apply(row(OP_SW, 0, 1, 4'd2, C_DEC, 0), "wd_sw decode");
        apply(row(OP_SW, 0, 1, 4'd6, C_MADDR, 0), "wd_sw maddr");
        for (int i = 0; i < 15; i++)
            apply(row(OP_SW, 0, 0, 4'd8, C_MWR, 0), $sformatf("wd_sw wait%0d", i));
        apply(row(OP_SW, 0, 0, 4'd15, 16'd0, 1), "halt");
        apply(row(OP_SW, 0, 1, 4'd15, 16'd0, 1), "halt stays");

        rst_i = 1'b0;
        #1;
        check("halt reset state", {28'd0, state_o}, 32'd0);
        check("halt reset timeout", {31'd0, timeout_o}, 32'd0);
        @(posedge clk_i); #1;
        rst_i = 1'b1;

        // Perf sequence: ADDI, ORI, BEQ (not taken), illegal opcode
        apply(row(OP_ADDI, 0, 1, 4'd0, 16'd0, 0), "perf idle");
        apply(row(OP_ADDI, 0, 1, 4'd1, C_FRDY, 0), "perf addi f");
        apply(row(OP_ADDI, 0, 1, 4'd2, C_DEC, 0), "perf addi d");
        apply(row(OP_ADDI, 0, 1, 4'd4, mk(0,0,0,0,0,0,1,2'd2,3'd1,0,0,0,0), 0), "perf addi e");
        apply(row(OP_ADDI, 0, 1, 4'd10, C_WBI, 0), "perf addi w");
        apply(row(OP_ORI, 0, 1, 4'd1, C_FRDY, 0), "perf ori f");
        apply(row(OP_ORI, 0, 1, 4'd2, C_DEC, 0), "perf ori d");
        apply(row(OP_ORI, 0, 1, 4'd4, mk(0,0,0,0,0,0,1,2'd2,3'd5,0,0,0,0), 0), "perf ori e");
        apply(row(OP_ORI, 0, 1, 4'd10, C_WBI, 0), "perf ori w");
        apply(row(OP_BEQ, 0, 1, 4'd1, C_FRDY, 0), "perf beq f");
        apply(row(OP_BEQ, 0, 1, 4'd2, C_DEC, 0), "perf beq d");
        apply(row(OP_BEQ, 0, 1, 4'd5, mk(0,0,0,0,0,0,1,2'd0,3'd3,0,0,1,0), 0), "perf beq b");
        apply(row(OP_BAD, 0, 1, 4'd1, C_FRDY, 0), "perf bad f");
        apply(row(OP_BAD, 0, 1, 4'd2, C_DECILL, 0), "perf bad d");
`ifdef MULTICYCLE_PERF_CNT_EN
        check("cycle_cnt 13", cycle_cnt_o, 32'd13);
        check("retire_cnt 3", retire_cnt_o, 32'd3);
`else
        check("cycle_cnt tied", cycle_cnt_o, 32'd0);
        check("retire_cnt tied", retire_cnt_o, 32'd0);
`endif
        apply(row(OP_R, 0, 0, 4'd1, C_FWAIT, 0), "perf fetch wait");
`ifdef MULTICYCLE_PERF_CNT_EN
        check("cycle_cnt 14", cycle_cnt_o, 32'd14);
        check("retire_cnt still 3", retire_cnt_o, 32'd3);
`else
        check("cycle_cnt tied 2", cycle_cnt_o, 32'd0);
        check("retire_cnt tied 2", retire_cnt_o, 32'd0);
`endif

        // Asynchronous reset while a fetch request is outstanding
        check("req before async reset", {31'd0, mem_req_o}, 32'd1);
        #2;
        rst_i = 1'b0;
        #1;
        check("async reset req drop", {31'd0, mem_req_o}, 32'd0);
        check("async reset state", {28'd0, state_o}, 32'd0);
        @(posedge clk_i); #1;
        check("held in reset", {28'd0, state_o}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
